// File: rtl/midi_cmd_rx.sv
// MIDI serial receiver and single-channel note command decoder.
// Each Note On/Off or All-Notes-Off message becomes one Avalon-MM write pulse.
module midi_cmd_rx #(
  parameter int CLKS_PER_BIT = 1600,
  parameter int CHANNEL      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_midi_rx,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  output logic        o_frame_err,
  output logic        o_busy
);

  localparam int              CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]      CH        = 4'(CHANNEL);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;
  typedef enum logic [1:0] {P_WAIT_STATUS, P_WAIT_D1, P_WAIT_D2} p_state_t;

  // ---------------- synchronizer and edge detect ----------------
  logic       rx_s1, rx_s2, rx_prev;
  logic [1:0] sync_ok;
  logic       fall;

  // sync_ok marks when rx_s2 holds a real line sample rather than its reset
  // value, so a line already low at reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      sync_ok <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of its neighbours.
      rx_s1   <= i_midi_rx;
      rx_s2   <= rx_s1;
      sync_ok <= {sync_ok[0], 1'b1};
      rx_prev <= rx_s2 & sync_ok[1];
    end
  end

  assign fall = rx_prev & ~rx_s2;

  // ---------------- receiver FSM ----------------
  rx_state_t     rx_state, rx_state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          stop_done, stop_done_d, stop_ok, stop_ok_d;
  logic          byte_valid;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    rx_state_d  = rx_state;
    cnt_d       = cnt + CW'(1);
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    stop_done_d = 1'b0;
    stop_ok_d   = stop_ok;
    case (rx_state)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) rx_state_d = RX_START;
      end
      RX_START:
        if (cnt == HALF_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = '0;
          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      RX_DATA:
        if (cnt == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s2, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_d = RX_STOP;
        end
      RX_STOP:
        if (cnt == BIT_LAST) begin
          cnt_d       = '0;
          stop_done_d = 1'b1;
          stop_ok_d   = rx_s2;
          rx_state_d  = rx_s2 ? RX_IDLE : RX_BREAK;
        end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s2) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      stop_done   <= 1'b0;
      stop_ok     <= 1'b0;
      byte_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      rx_state    <= rx_state_d;
      cnt         <= cnt_d;
      bit_idx     <= bit_idx_d;
      shreg       <= shreg_d;
      stop_done   <= stop_done_d;
      stop_ok     <= stop_ok_d;
      byte_valid  <= stop_done & stop_ok;
      o_frame_err <= stop_done & ~stop_ok;
      o_busy      <= (rx_state_d != RX_IDLE);
    end
  end

  // ---------------- message parser ----------------
  // Running status only needs the message type nibble: the channel is fixed.
  p_state_t    ps, ps_d;
  logic [3:0]  rs, rs_d;
  logic        rs_valid, rs_valid_d;
  logic [6:0]  d1, d1_d;
  logic        wr, wr_d;
  logic [15:0] cmd, cmd_d;
  logic [7:0]  rx_byte;

  assign rx_byte = shreg;

  always_comb begin
    ps_d       = ps;
    rs_d       = rs;
    rs_valid_d = rs_valid;
    d1_d       = d1;
    wr_d       = 1'b0;
    cmd_d      = cmd;
    if (byte_valid) begin
      if (rx_byte >= 8'hF8) begin
        // real-time bytes pass through without disturbing the message
      end else if (rx_byte >= 8'hF0) begin
        rs_valid_d = 1'b0;
        ps_d       = P_WAIT_STATUS;
      end else if (rx_byte[7]) begin
        if (rx_byte[3:0] == CH &&
            (rx_byte[7:4] == 4'h8 || rx_byte[7:4] == 4'h9 || rx_byte[7:4] == 4'hB)) begin
          rs_d       = rx_byte[7:4];
          rs_valid_d = 1'b1;
          ps_d       = P_WAIT_D1;
        end else begin
          rs_valid_d = 1'b0;
          ps_d       = P_WAIT_STATUS;
        end
      end else begin
        case (ps)
          P_WAIT_STATUS:
            if (rs_valid) begin
              d1_d = rx_byte[6:0];
              ps_d = P_WAIT_D2;
            end
          P_WAIT_D1: begin
            d1_d = rx_byte[6:0];
            ps_d = P_WAIT_D2;
          end
          P_WAIT_D2: begin
            ps_d = P_WAIT_STATUS;
            case (rs)
              4'h9:
                if (d1 != 7'h7F) begin
                  wr_d  = 1'b1;
                  cmd_d = (rx_byte[6:0] != 7'h00) ? {1'b1, d1, 1'b0, rx_byte[6:0]}
                                                  : {1'b0, d1, 8'h00};
                end
              4'h8:
                if (d1 != 7'h7F) begin
                  wr_d  = 1'b1;
                  cmd_d = {1'b0, d1, 8'h00};
                end
              4'hB:
                if (d1 == 7'd120 || d1 == 7'd123) begin
                  wr_d  = 1'b1;
                  cmd_d = 16'h7F00;
                end
              default: ;
            endcase
          end
          default: ps_d = P_WAIT_STATUS;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps       <= P_WAIT_STATUS;
      rs       <= '0;
      rs_valid <= 1'b0;
      d1       <= '0;
      wr       <= 1'b0;
      cmd      <= '0;
    end else begin
      ps       <= ps_d;
      rs       <= rs_d;
      rs_valid <= rs_valid_d;
      d1       <= d1_d;
      wr       <= wr_d;
      cmd      <= cmd_d;
    end
  end

  assign avm_m0_write     = wr;
  assign avm_m0_writedata = {16'h0000, cmd};

endmodule

// File: tb/tb_midi_cmd_rx.sv
// Self-checking bench for midi_cmd_rx: serial byte driver, expected-write
// queue popped by a write monitor, message table plus multi-cycle corner cases.
`timescale 1ns/1ps
module tb_midi_cmd_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        midi;
  logic        avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic        o_frame_err;
  logic        o_busy;

  midi_cmd_rx #(.CLKS_PER_BIT(CPB), .CHANNEL(0)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_midi_rx        (midi),
    .avm_m0_write     (avm_m0_write),
    .avm_m0_writedata (avm_m0_writedata),
    .o_frame_err      (o_frame_err),
    .o_busy           (o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          fe_cnt = 0;
  int          last_wr_cyc  = 0;
  int          last_bit_cyc = 0;
  logic [15:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every observed write must match the next expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && avm_m0_write === 1'b1) begin
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: got %h, expected no write", avm_m0_writedata);
      end else begin
        check("writedata", avm_m0_writedata, {16'h0000, exp_q.pop_front()});
      end
    end
    if (o_frame_err === 1'b1) fe_cnt++;
  end

  task automatic send_bit(input logic v);
    @(posedge clk);
    #1 midi = v;
    last_bit_cyc = cyc;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    for (int i = 0; i < stop_low; i++) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  typedef struct {
    logic [8*12-1:0] name;
    int              n;
    logic [7:0]      b [6];
    int              ne;
    logic [15:0]     e [2];
  } vec_t;

  vec_t vecs [10];

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{"note_on",  3, '{8'h90, 8'h40, 8'h64, 8'h00, 8'h00, 8'h00}, 1, '{16'hC064, 16'h0000}};
    vecs[1] = '{"running",  5, '{8'h90, 8'h45, 8'h10, 8'h45, 8'h00, 8'h00}, 2, '{16'hC510, 16'h4500}};
    vecs[2] = '{"cc_off",   3, '{8'hB0, 8'h7B, 8'h00, 8'h00, 8'h00, 8'h00}, 1, '{16'h7F00, 16'h0000}};
    vecs[3] = '{"other_ch", 3, '{8'h91, 8'h40, 8'h64, 8'h00, 8'h00, 8'h00}, 0, '{16'h0000, 16'h0000}};
    vecs[4] = '{"realtime", 4, '{8'h90, 8'hF8, 8'h3C, 8'h7F, 8'h00, 8'h00}, 1, '{16'hBC7F, 16'h0000}};
    vecs[5] = '{"note127",  3, '{8'h90, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00}, 0, '{16'h0000, 16'h0000}};
    vecs[6] = '{"note_off", 3, '{8'h80, 8'h3C, 8'h40, 8'h00, 8'h00, 8'h00}, 1, '{16'h3C00, 16'h0000}};
    vecs[7] = '{"cc_other", 3, '{8'hB0, 8'h07, 8'h40, 8'h00, 8'h00, 8'h00}, 0, '{16'h0000, 16'h0000}};
    vecs[8] = '{"abort",    5, '{8'h90, 8'h40, 8'hB0, 8'h78, 8'h00, 8'h00}, 1, '{16'h7F00, 16'h0000}};
    vecs[9] = '{"sysex",    4, '{8'h90, 8'hF0, 8'h40, 8'h64, 8'h00, 8'h00}, 0, '{16'h0000, 16'h0000}};

    // reset state
    reset = 1'b0;
    midi  = 1'b1;
    idle(3);
    @(negedge clk);
    check("rst_write", {31'd0, avm_m0_write}, 32'd0);
    check("rst_data",  avm_m0_writedata, 32'd0);
    check("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    reset = 1'b1;
    idle(2 * CPB);

    // message table
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < vecs[k].ne; j++) exp_q.push_back(vecs[k].e[j]);
      for (int j = 0; j < vecs[k].n; j++) send_byte(vecs[k].b[j], 0);
      idle(3 * CPB);
      check($sformatf("drain_%0s", vecs[k].name), exp_q.size(), 0);
      if (vecs[k].ne > 0)
        check($sformatf("held_%0s", vecs[k].name), avm_m0_writedata,
              {16'h0000, vecs[k].e[vecs[k].ne - 1]});
      // write lands two clocks after the mid-bit stop sample: 13 clocks after stop drive
      if (k == 0) check("latency", last_wr_cyc - last_bit_cyc, 13);
    end

    // framing error: stop held low for 3 bit times, then a good message
    begin
      int fe0;
      fe0 = fe_cnt;
      send_byte(8'h90, 3);
      exp_q.push_back(16'hBC01);
      send_byte(8'h90, 0);
      send_byte(8'h3C, 0);
      send_byte(8'h01, 0);
      idle(3 * CPB);
      check("frame_err_pulses", fe_cnt - fe0, 1);
      check("drain_frame", exp_q.size(), 0);
    end

    // 4-clock glitch: start rejected at mid-bit, no byte, no error
    begin
      int fe0;
      fe0 = fe_cnt;
      @(posedge clk);
      #1 midi = 1'b0;
      idle(4);
      #1 midi = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("glitch_busy_hi", {31'd0, o_busy}, 32'd1);
      idle(2 * CPB);
      @(negedge clk);
      check("glitch_busy_lo", {31'd0, o_busy}, 32'd0);
      check("glitch_no_err", fe_cnt - fe0, 0);
    end

    // reset released while the line is already low: no frame starts
    midi  = 1'b0;
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2 * CPB);
    @(negedge clk);
    check("low_line_busy", {31'd0, o_busy}, 32'd0);
    midi = 1'b1;
    idle(2 * CPB);

    // reset during bit 4 of D2, then running-status data must be ignored
    send_byte(8'h90, 0);
    send_byte(8'h40, 0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h64 >> i));
    @(posedge clk);
    #1 midi = 1'b0;
    idle(5);
    #1 reset = 1'b0;
    #1;
    check("midrst_write", {31'd0, avm_m0_write}, 32'd0);
    check("midrst_data",  avm_m0_writedata, 32'd0);
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    midi = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(2 * CPB);
    send_byte(8'h40, 0);
    send_byte(8'h64, 0);
    idle(3 * CPB);
    check("drain_midrst", exp_q.size(), 0);

    // recovery after reset
    exp_q.push_back(16'hBC01);
    send_byte(8'h90, 0);
    send_byte(8'h3C, 0);
    send_byte(8'h01, 0);
    idle(3 * CPB);
    check("drain_recover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
